led_frame_ctrl: RTL and testbench
=================================

# led_frame_ctrl

Frame-level sequencer for the LED-array PMod. It holds a 16-column × 8-bit frame buffer written by the host logic. On demand, or periodically, it drives the byte writer through one complete display refresh: data-command byte, address byte, all column bytes, then display-control byte. It sits between user logic and the byte writer, and is the only master of the writer's valid/value handshake.

## Interface
Parameters:
- NUM_COLS, 16: column bytes per frame; 1..16. The address counter is 4 bits.
- REFRESH_CYCLES, 0: clk cycles between automatic refreshes. 0 disables auto refresh. Otherwise 1..2^24-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  frame buffer write strobe.
- wr_addr  in  4  column index. Writes with wr_addr ≥ NUM_COLS are ignored.
- wr_data  in  8  column pixel byte; bit 0 is the top row.
- update  in  1  single-cycle refresh request.
- brightness  in  3  PWM level, sampled when the display-control byte is issued.
- display_on  in  1  display enable, sampled with brightness.
- byte_valid  out  1  one-cycle strobe: byte_value/byte_first/byte_last are valid.
- byte_value  out  8  byte for the writer.
- byte_first  out  1  writer emits a start condition before this byte.
- byte_last  out  1  writer emits a stop condition after this byte.
- byte_busy  in  1  writer transmitting.
- ctrl_busy  out  1  refresh in progress (state ≠ IDLE).
- frame_done  out  1  one-cycle pulse when the final byte completes.

## Operation
- Frame buffer:
  - NUM_COLS × 8 registers, cleared to 0x00 on reset.
  - Writes are accepted in every state.
  - A column byte is read in the cycle it is issued. A write to a column not yet sent appears in the current frame; a write to a column already sent appears in the next frame.
- Byte sequence per frame: N+3 bytes, where N = NUM_COLS.
  1. 0x40, first=1, last=1 (auto-increment data command).
  2. 0xC0, first=1, last=0 (address 0).
  3. buf[0]..buf[N-1], first=0; last=1 only on buf[N-1].
  4. Display-control byte, first=1, last=1:
     - 0x88 | brightness when display_on=1.
     - 0x80 when display_on=0.
- States:
  - IDLE
  - ISSUE: registered byte_valid high for this cycle only.
  - WAIT_BUSY: wait for byte_busy=1.
  - WAIT_DONE: wait for byte_busy=0.
  - After WAIT_DONE, step to the next byte's ISSUE, or to IDLE after the final byte.
  - A byte-select register (CMD, ADDR, DATA, DISP) and a 4-bit column counter choose the byte.
- Trigger sources in IDLE: update, pending, or auto-refresh tick. Any of these starts a frame.
- Pending flag:
  - Set by update or an auto tick while ctrl_busy=1.
  - Cleared when a frame starts.
  - Multiple requests during one frame collapse into a single extra frame.
- Auto-refresh counter:
  - Free-running; wraps at REFRESH_CYCLES-1.
  - Produces a one-cycle tick on wrap.
  - Is not reset by manual updates.
- Simultaneous update and tick in IDLE start a single frame; pending stays 0.
- rst_n low at any point, including mid-byte:
  - Immediate return to IDLE.
  - All outputs 0, buffer cleared, pending cleared, counters cleared.
  - The writer's own reset is responsible for aborting its line activity.

## Timing
- Reset values: byte_valid=0, byte_value=0x00, byte_first=0, byte_last=0, ctrl_busy=0, frame_done=0.
- Start latency: update high in cycle t (IDLE) gives byte_valid=1 and ctrl_busy=1 in cycle t+1.
- Byte stepping: byte_busy falls in cycle u (seen in WAIT_DONE) → next byte_valid in cycle u+1.
- No timeout: if byte_busy never rises, the block waits in WAIT_BUSY indefinitely.
- frame_done:
  - Pulses in the cycle after the final byte's byte_busy fall is seen.
  - ctrl_busy goes 0 in that same cycle.
- Back-to-back frames: with pending=1, the next frame's byte_valid comes one cycle after frame_done, via IDLE.
- byte_value, byte_first and byte_last hold their values until the next ISSUE.

## Test plan
Bench writer model: byte_busy rises 1 cycle after byte_valid and stays high 20 cycles.
- Reset: release rst_n → all outputs 0, ctrl_busy=0. Issue update with the buffer never written → 19 bytes: 0x40, 0xC0, sixteen 0x00, 0x80|… per display_on/brightness.
- Pattern frame: write buf[i]=i*0x11, brightness=5, display_on=1, pulse update → byte sequence 0x40, 0xC0, 0x00, 0x11 … 0xFF, 0x8D with correct first/last flags; frame_done once; latency t+1 checked.
- Concurrency:
  - Three update pulses during a frame → exactly one extra frame.
  - A write to buf[15] while buf[3] is in flight → new value is sent in the current frame.
- Display off and auto refresh: display_on=0 → last byte 0x80. With REFRESH_CYCLES=2000 → frame starts every 2000 cycles, including a tick coincident with update (one frame only).
- Edge cases:
  - rst_n asserted during byte 7 → outputs 0 within the same cycle and buffer reads back 0.
  - A write to wr_addr=NUM_COLS with NUM_COLS=8 → ignored, and the frame has 11 bytes.

Source files
------------

// File: rtl/led_frame_ctrl.sv
// Frame sequencer for the LED-array PMod: holds a column frame buffer and walks the
// byte writer through command, address, column and display-control bytes.
module led_frame_ctrl #(
    parameter int NUM_COLS       = 16,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       update,
    input  logic [2:0] brightness,
    input  logic       display_on,
    output logic       byte_valid,
    output logic [7:0] byte_value,
    output logic       byte_first,
    output logic       byte_last,
    input  logic       byte_busy,
    output logic       ctrl_busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
    typedef enum logic [1:0] {SEL_CMD, SEL_ADDR, SEL_DATA, SEL_DISP} sel_t;

    localparam logic [3:0]  LAST_COL     = 4'(NUM_COLS - 1);
    localparam logic [4:0]  COL_LIMIT    = 5'(NUM_COLS);
    localparam bit          AUTO_EN      = (REFRESH_CYCLES != 0);
    localparam logic [23:0] REFRESH_LAST = AUTO_EN ? 24'(REFRESH_CYCLES - 1) : 24'd0;

    state_t      state;
    sel_t        sel;
    logic [3:0]  col_cnt;
    logic [3:0]  next_col;
    logic        pending;
    logic [23:0] refresh_cnt;
    logic        refresh_tick;
    logic [7:0]  disp_byte;
    // Sized for the full 4-bit address so the column counter indexes it directly;
    // entries at or above NUM_COLS are never written and stay at zero.
    logic [7:0]  frame_buf [16];

    assign refresh_tick = AUTO_EN && (refresh_cnt == REFRESH_LAST);
    assign next_col     = col_cnt + 4'd1;
    assign disp_byte    = display_on ? {5'b10001, brightness} : 8'h80;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
        end else if (!AUTO_EN || refresh_tick) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                frame_buf[i] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_addr} < COL_LIMIT)) begin
            frame_buf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= SEL_CMD;
            col_cnt    <= '0;
            pending    <= 1'b0;
            byte_valid <= 1'b0;
            byte_value <= '0;
            byte_first <= 1'b0;
            byte_last  <= 1'b0;
            ctrl_busy  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            if (state != IDLE && (update || refresh_tick)) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (update || refresh_tick || pending) begin
                        state      <= ISSUE;
                        sel        <= SEL_CMD;
                        col_cnt    <= '0;
                        pending    <= 1'b0;
                        ctrl_busy  <= 1'b1;
                        byte_valid <= 1'b1;
                        byte_value <= 8'h40;
                        byte_first <= 1'b1;
                        byte_last  <= 1'b1;
                    end
                end
                ISSUE: state <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (byte_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!byte_busy) begin
                        state      <= ISSUE;
                        byte_valid <= 1'b1;
                        case (sel)
                            SEL_CMD: begin
                                sel        <= SEL_ADDR;
                                byte_value <= 8'hC0;
                                byte_first <= 1'b1;
                                byte_last  <= 1'b0;
                            end
                            SEL_ADDR: begin
                                sel        <= SEL_DATA;
                                col_cnt    <= '0;
                                byte_value <= frame_buf[0];
                                byte_first <= 1'b0;
                                byte_last  <= (LAST_COL == 4'd0);
                            end
                            SEL_DATA: begin
                                if (col_cnt == LAST_COL) begin
                                    sel        <= SEL_DISP;
                                    byte_value <= disp_byte;
                                    byte_first <= 1'b1;
                                    byte_last  <= 1'b1;
                                end else begin
                                    col_cnt    <= next_col;
                                    byte_value <= frame_buf[next_col];
                                    byte_first <= 1'b0;
                                    byte_last  <= (next_col == LAST_COL);
                                end
                            end
                            default: begin
                                state      <= IDLE;
                                byte_valid <= 1'b0;
                                ctrl_busy  <= 1'b0;
                                frame_done <= 1'b1;
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Scoreboard bench: expected byte streams are queued from a frame model when
// refreshes are requested; per-DUT monitors pop and compare each issued byte.
module tb_led_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: 16 columns, no auto refresh. dut1: 8 columns, refresh every 2000 cycles.
    logic       rst0_n = 1'b0, wr_en0 = 1'b0, update0 = 1'b0, on0 = 1'b0, busy0;
    logic [3:0] wr_addr0 = '0;
    logic [7:0] wr_data0 = '0, bval0;
    logic [2:0] bri0 = '0;
    logic       bv0, bf0, bl0, cb0, fd0;

    logic       rst1_n = 1'b0, wr_en1 = 1'b0, update1 = 1'b0, on1 = 1'b0, busy1;
    logic [3:0] wr_addr1 = '0;
    logic [7:0] wr_data1 = '0, bval1;
    logic [2:0] bri1 = '0;
    logic       bv1, bf1, bl1, cb1, fd1;

    led_frame_ctrl #(.NUM_COLS(16), .REFRESH_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .update(update0), .brightness(bri0), .display_on(on0), .byte_valid(bv0),
        .byte_value(bval0), .byte_first(bf0), .byte_last(bl0), .byte_busy(busy0),
        .ctrl_busy(cb0), .frame_done(fd0));

    led_frame_ctrl #(.NUM_COLS(8), .REFRESH_CYCLES(2000)) dut1 (
        .clk(clk), .rst_n(rst1_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .update(update1), .brightness(bri1), .display_on(on1), .byte_valid(bv1),
        .byte_value(bval1), .byte_first(bf1), .byte_last(bl1), .byte_busy(busy1),
        .ctrl_busy(cb1), .frame_done(fd1));

    int n_checks = 0, n_fail = 0;
    int seen0 = 0, done0 = 0, seen1 = 0, done1 = 0, starts1 = 0, edges1 = 0;
    int bcnt0, bcnt1;
    logic [9:0] q0[$], q1[$];
    logic [7:0] mb0 [16], mb1 [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Writer model: busy rises one cycle after byte_valid and holds for 20 cycles.
    always @(posedge clk or negedge rst0_n) begin
        if (!rst0_n) begin busy0 <= 1'b0; bcnt0 <= 0; end
        else if (bv0) begin busy0 <= 1'b1; bcnt0 <= 19; end
        else if (busy0) begin
            if (bcnt0 == 0) busy0 <= 1'b0; else bcnt0 <= bcnt0 - 1;
        end
    end
    always @(posedge clk or negedge rst1_n) begin
        if (!rst1_n) begin busy1 <= 1'b0; bcnt1 <= 0; end
        else if (bv1) begin busy1 <= 1'b1; bcnt1 <= 19; end
        else if (busy1) begin
            if (bcnt1 == 0) busy1 <= 1'b0; else bcnt1 <= bcnt1 - 1;
        end
    end

    always @(posedge clk) begin
        if (!rst1_n) edges1 <= 0; else edges1 <= edges1 + 1;
    end

    always @(negedge clk) begin
        if (rst0_n) begin
            if (bv0) begin
                if (q0.size() == 0) check("dut0_unexpected_byte", {22'd0, bval0, bf0, bl0}, 32'hFFFF_FFFF);
                else check("dut0_byte", {22'd0, bval0, bf0, bl0}, {22'd0, q0.pop_front()});
                check("dut0_busy_with_valid", {31'd0, cb0}, 32'd1);
                seen0++;
            end
            if (fd0) begin
                done0++;
                check("dut0_idle_at_done", {31'd0, cb0}, 32'd0);
            end
        end
        if (rst1_n) begin
            if (bv1) begin
                if (q1.size() == 0) check("dut1_unexpected_byte", {22'd0, bval1, bf1, bl1}, 32'hFFFF_FFFF);
                else check("dut1_byte", {22'd0, bval1, bf1, bl1}, {22'd0, q1.pop_front()});
                if (bf1 && bval1 == 8'h40) begin
                    starts1++;
                    check("dut1_start_period", edges1 % 2000, 32'd0);
                end
                seen1++;
            end
            if (fd1) done1++;
        end
    end

    task automatic push_frame(input int which, input int ncols, input logic [2:0] bri, input logic on);
        logic [9:0] e [$];
        e.push_back({8'h40, 2'b11});
        e.push_back({8'hC0, 2'b10});
        for (int i = 0; i < ncols; i++)
            e.push_back({(which == 0) ? mb0[i] : mb1[i], 1'b0, (i == ncols - 1)});
        e.push_back({on ? (8'h88 | {5'd0, bri}) : 8'h80, 2'b11});
        foreach (e[k]) begin
            if (which == 0) q0.push_back(e[k]); else q1.push_back(e[k]);
        end
    endtask

    task automatic write0(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1 wr_en0 = 1'b1; wr_addr0 = a; wr_data0 = d;
        @(posedge clk); #1 wr_en0 = 1'b0;
    endtask

    task automatic write1(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1 wr_en1 = 1'b1; wr_addr1 = a; wr_data1 = d;
        @(posedge clk); #1 wr_en1 = 1'b0;
    endtask

    task automatic pulse_update0(input bit chk);
        @(posedge clk); #1 update0 = 1'b1;
        @(posedge clk); #1 update0 = 1'b0;
        if (chk) begin
            check("dut0_start_valid", {31'd0, bv0}, 32'd1);
            check("dut0_start_busy", {31'd0, cb0}, 32'd1);
        end
    endtask

    task automatic wait_done0(input int target);
        int n = 0;
        while (done0 < target && n < 3000) begin @(posedge clk); n++; end
        check("dut0_frame_done_wait", {31'd0, done0 >= target}, 32'd1);
    endtask

    task automatic wait_seen0(input int target);
        int n = 0;
        while (seen0 < target && n < 3000) begin @(posedge clk); n++; end
        check("dut0_byte_wait", {31'd0, seen0 >= target}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, d;
        logic [7:0] v15;
        foreach (mb0[i]) mb0[i] = 8'h00;
        foreach (mb1[i]) mb1[i] = 8'h00;

        // Reset and unwritten buffer
        repeat (3) @(posedge clk);
        check("dut0_in_reset_outputs", {26'd0, bv0, bval0, bf0, bl0, cb0, fd0}, 32'd0);
        #1 rst0_n = 1'b1;
        @(posedge clk); #1;
        check("dut0_after_reset_outputs", {26'd0, bv0, bval0, bf0, bl0, cb0, fd0}, 32'd0);
        bri0 = 3'($urandom_range(0, 7)); on0 = 1'($urandom_range(0, 1));
        push_frame(0, 16, bri0, on0);
        pulse_update0(1);
        wait_done0(1);
        check("dut0_blank_frame_drained", q0.size(), 32'd0);

        // Pattern frame i*0x11, brightness 5, display on
        for (int i = 0; i < 16; i++) begin mb0[i] = 8'(i * 17); write0(4'(i), mb0[i]); end
        bri0 = 3'd5; on0 = 1'b1;
        push_frame(0, 16, bri0, on0);
        pulse_update0(1);
        wait_done0(2);
        check("dut0_pattern_frame_count", done0, 32'd2);

        // Three requests during a frame collapse into one extra frame
        for (int i = 0; i < 16; i++) begin mb0[i] = 8'($urandom_range(1, 255)); write0(4'(i), mb0[i]); end
        bri0 = 3'($urandom_range(0, 7)); on0 = 1'($urandom_range(0, 1));
        push_frame(0, 16, bri0, on0);
        push_frame(0, 16, bri0, on0);
        d = done0; base = seen0;
        pulse_update0(1);
        wait_seen0(base + 4);
        for (int k = 0; k < 3; k++) begin pulse_update0(0); repeat (30) @(posedge clk); end
        wait_done0(d + 2);
        repeat (200) @(posedge clk);
        check("dut0_single_extra_frame", done0, d + 2);
        check("dut0_extra_frame_drained", q0.size(), 32'd0);

        // Write to column 15 while column 3 is in flight lands in this frame
        v15 = 8'($urandom_range(1, 255)) ^ mb0[15];
        if (v15 == 8'h00) v15 = 8'h5A;
        mb0[15] = v15;
        push_frame(0, 16, bri0, on0);
        d = done0; base = seen0;
        pulse_update0(1);
        wait_seen0(base + 6);
        write0(4'd15, v15);
        wait_done0(d + 1);
        check("dut0_late_write_drained", q0.size(), 32'd0);

        // Reset during byte 7, then the buffer must read back as zero
        push_frame(0, 16, bri0, on0);
        base = seen0;
        pulse_update0(1);
        wait_seen0(base + 7);
        repeat (5) @(posedge clk);
        #1 rst0_n = 1'b0;
        #1 check("dut0_midframe_reset_outputs", {26'd0, bv0, bval0, bf0, bl0, cb0, fd0}, 32'd0);
        q0.delete();
        repeat (3) @(posedge clk);
        #1 rst0_n = 1'b1;
        foreach (mb0[i]) mb0[i] = 8'h00;
        bri0 = 3'($urandom_range(0, 7)); on0 = 1'b1;
        push_frame(0, 16, bri0, on0);
        d = done0;
        pulse_update0(1);
        wait_done0(d + 1);
        check("dut0_cleared_frame_drained", q0.size(), 32'd0);

        // dut1: auto refresh, display off, out-of-range write ignored
        @(posedge clk); #1 rst1_n = 1'b1;
        @(posedge clk); #1;
        check("dut1_after_reset_outputs", {26'd0, bv1, bval1, bf1, bl1, cb1, fd1}, 32'd0);
        for (int i = 0; i < 8; i++) begin mb1[i] = 8'($urandom_range(1, 255)); write1(4'(i), mb1[i]); end
        write1(4'd8, 8'($urandom_range(1, 255)));
        bri1 = 3'($urandom_range(1, 7)); on1 = 1'b0;
        for (int k = 0; k < 3; k++) push_frame(1, 8, bri1, on1);
        begin
            int n = 0;
            while (edges1 != 3999 && n < 5000) begin @(posedge clk); #1; n++; end
            check("dut1_reach_tick_cycle", edges1, 32'd3999);
        end
        update1 = 1'b1;
        @(posedge clk); #1 update1 = 1'b0;
        while (edges1 < 6400) @(posedge clk);
        check("dut1_frames_started", starts1, 32'd3);
        check("dut1_frames_done", done1, 32'd3);
        check("dut1_bytes_seen", seen1, 32'd33);
        check("dut1_queue_drained", q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
